// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM states and control-word bit indices shared by the alu files
package alu_pkg;
   localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100, OP_DIV = 3'b101, OP_XOR = 3'b110;
   typedef enum logic [2:0] {IDLE, LOAD, EXEC, ITER, FIX, DONE} state_t;
   localparam int C_LOAD = 0, C_ADD = 1, C_SUB = 2, C_ASUM = 3, C_ASR = 4, C_SHL = 5;
   localparam int C_Q1 = 6, C_Q0 = 7, C_RESTORE = 8, C_CNT = 9, C_AND = 10, C_OR = 11;
   localparam int C_XOR = 12, C_QFIX = 13, C_RFIX = 14, C_OUTV = 15, C_END = 16, C_IDLE = 17;
endpackage

// File: rtl/alu_adder.sv
// alu_adder: 8-bit add/subtract with carry (borrow when subtracting) and signed overflow
// ports: a_i, b_i operands; sub_i selects a-b; sum_o low 8 bits; co_o carry/borrow; ovf_o signed overflow
module alu_adder
   import alu_pkg::*;
(
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  logic       sub_i,
   output logic [7:0] sum_o,
   output logic       co_o,
   output logic       ovf_o
);
   logic [8:0] t;
   assign t     = sub_i ? {1'b0, a_i} - {1'b0, b_i} : {1'b0, a_i} + {1'b0, b_i};
   assign sum_o = t[7:0];
   assign co_o  = t[8];
   assign ovf_o = (a_i[7] ^ t[7]) & (sub_i ? a_i[7] ^ b_i[7] : ~(a_i[7] ^ b_i[7]));
endmodule

// File: rtl/alu.sv
// alu: sequential 8-bit signed ALU (add/sub/logic in one cycle, Booth multiply, restoring divide)
// ports: clk, resetn (sync, active low); X, Y operands; op select; BEGIN start; OUT = {A,Q};
//        END done pulse; ovr overflow/divide error; A, Q, count, q8, r, m, sum_out, control debug
// ALU_DEBUG_PORTS_EN: when defined the debug ports follow internal state, otherwise they read 0
module alu
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic [7:0]  X,
   input  logic [7:0]  Y,
   input  logic [2:0]  op,
   input  logic        BEGIN,
   output logic [15:0] OUT,
   output logic        END,
   output logic [7:0]  A,
   output logic [7:0]  Q,
   output logic [2:0]  count,
   output logic        ovr,
   output logic        q8,
   output logic        r,
   output logic [7:0]  m,
   output logic [7:0]  sum_out,
   output logic [17:0] control
);
   state_t     state_q;
   logic [2:0] op_q, cnt_q;
   logic [7:0] a_q, q_q, m_q, sum, ain, bin, sa, lres;
   logic       q8_q, ovr_q, end_q, xs_q, ys_q, sub, co, ovf, sgn, it_mul, it_div, iterate;

   always_comb begin
      it_mul  = state_q == ITER && op_q == OP_MUL;
      it_div  = state_q == ITER && op_q == OP_DIV;
      iterate = op == OP_MUL || (op == OP_DIV && Y != 8'd0);
      sa      = {a_q[6:0], q_q[7]};
      ain     = it_div ? sa : a_q;
      // Booth pairs 00/11 add nothing, so feed zero and let the shift proceed
      bin     = it_mul && q_q[0] == q8_q ? 8'd0 : m_q;
      sub     = state_q == ITER ? it_div || (q_q[0] && !q8_q) : op_q == OP_SUB;
      // true sign of the 9-bit result; keeps the Booth shift exact when A-M leaves 8-bit range
      sgn     = sum[7] ^ ovf;
      lres    = op_q == OP_AND ? a_q & m_q : op_q == OP_OR ? a_q | m_q : op_q == OP_XOR ? a_q ^ m_q : 8'd0;
   end

   alu_adder u_add (.a_i(ain), .b_i(bin), .sub_i(sub), .sum_o(sum), .co_o(co), .ovf_o(ovf));

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         op_q    <= '0;
         cnt_q   <= '0;
         a_q     <= '0;
         q_q     <= '0;
         m_q     <= '0;
         q8_q    <= 1'b0;
         ovr_q   <= 1'b0;
         end_q   <= 1'b0;
         xs_q    <= 1'b0;
         ys_q    <= 1'b0;
      end else begin
         end_q <= 1'b0;
         case (state_q)
            IDLE: if (BEGIN) state_q <= LOAD;
            LOAD: begin
               op_q    <= op;
               cnt_q   <= '0;
               q8_q    <= 1'b0;
               ovr_q   <= 1'b0;
               xs_q    <= X[7];
               ys_q    <= Y[7];
               // a divide by zero keeps the dividend in A as its error result
               a_q     <= iterate ? 8'd0 : X;
               q_q     <= op == OP_MUL ? Y : op == OP_DIV ? (X[7] ? -X : X) : 8'd0;
               m_q     <= op == OP_MUL ? X : op == OP_DIV ? (Y[7] ? -Y : Y) : Y;
               state_q <= iterate ? ITER : EXEC;
            end
            EXEC: begin
               if (op_q == OP_DIV) begin
                  q_q   <= 8'hFF;
                  ovr_q <= 1'b1;
               end else if (op_q == OP_ADD || op_q == OP_SUB) begin
                  q_q   <= sum;
                  a_q   <= {8{sgn}};
                  ovr_q <= ovf;
               end else begin
                  q_q   <= lres;
                  a_q   <= '0;
               end
               state_q <= DONE;
               end_q   <= 1'b1;
            end
            ITER: begin
               cnt_q <= cnt_q + 3'd1;
               if (op_q == OP_MUL) begin
                  a_q  <= {sgn, sum[7:1]};
                  q_q  <= {sum[0], q_q[7:1]};
                  q8_q <= q_q[0];
               end else begin
                  a_q  <= co ? sa : sum;
                  q_q  <= {q_q[6:0], !co};
               end
               if (cnt_q == 3'd7) begin
                  state_q <= op_q == OP_DIV ? FIX : DONE;
                  end_q   <= op_q != OP_DIV;
               end
            end
            FIX: begin
               q_q     <= xs_q ^ ys_q ? -q_q : q_q;
               a_q     <= xs_q ? -a_q : a_q;
               // only -128 / -1 yields an unsigned quotient of 128 that stays positive
               ovr_q   <= !(xs_q ^ ys_q) && q_q[7];
               state_q <= DONE;
               end_q   <= 1'b1;
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign OUT = {a_q, q_q};
   assign END = end_q;
   assign ovr = ovr_q;

`ifdef ALU_DEBUG_PORTS_EN
   assign A       = a_q;
   assign Q       = q_q;
   assign count   = cnt_q;
   assign q8      = q8_q;
   assign r       = it_div && co;
   assign m       = m_q;
   assign sum_out = sum;
   always_comb begin
      control            = '0;
      control[C_IDLE]    = state_q == IDLE;
      control[C_LOAD]    = state_q == LOAD;
      control[C_ADD]     = (state_q == EXEC && op_q == OP_ADD) || (it_mul && !q_q[0] && q8_q);
      control[C_SUB]     = (state_q == EXEC && op_q == OP_SUB) || (it_mul && q_q[0] && !q8_q) || it_div;
      control[C_ASUM]    = (state_q == EXEC && (op_q == OP_ADD || op_q == OP_SUB)) || (it_mul && (q_q[0] ^ q8_q)) || (it_div && !co);
      control[C_ASR]     = it_mul;
      control[C_SHL]     = it_div;
      control[C_Q1]      = it_div && !co;
      control[C_Q0]      = it_div && co;
      control[C_RESTORE] = it_div && co;
      control[C_CNT]     = state_q == ITER;
      control[C_AND]     = state_q == EXEC && op_q == OP_AND;
      control[C_OR]      = state_q == EXEC && op_q == OP_OR;
      control[C_XOR]     = state_q == EXEC && op_q == OP_XOR;
      control[C_QFIX]    = state_q == FIX && (xs_q ^ ys_q);
      control[C_RFIX]    = state_q == FIX && xs_q;
      control[C_OUTV]    = state_q == DONE;
      control[C_END]     = state_q == DONE;
   end
`else
   assign A       = '0;
   assign Q       = '0;
   assign count   = '0;
   assign q8      = 1'b0;
   assign r       = 1'b0;
   assign m       = '0;
   assign sum_out = '0;
   assign control = '0;
`endif
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for the sequential alu
module tb_alu;
   logic        clk = 1'b0, resetn = 1'b0, BEGIN = 1'b0;
   logic [7:0]  X = '0, Y = '0;
   logic [2:0]  op = '0;
   logic [15:0] OUT;
   logic        END, ovr, q8, r;
   logic [7:0]  A, Q, m, sum_out;
   logic [2:0]  count;
   logic [17:0] control;
   int total = 0, bad = 0;

   alu dut (.clk(clk), .resetn(resetn), .X(X), .Y(Y), .op(op), .BEGIN(BEGIN), .OUT(OUT), .END(END),
            .A(A), .Q(Q), .count(count), .ovr(ovr), .q8(q8), .r(r), .m(m), .sum_out(sum_out),
            .control(control));

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // operands are junk on the BEGIN edge, valid on the LOAD edge, and junk again afterwards
   task automatic run(input string tag, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                      input logic [15:0] eo, input logic eovr, input int lat, input bit poke);
      int j;
      @(negedge clk);
      op = ~o; X = ~x; Y = ~y; BEGIN = 1'b1;
      @(posedge clk); #1;
      op = o; X = x; Y = y; BEGIN = 1'b0;
      @(posedge clk); #1;
      op = 3'($urandom); X = 8'($urandom); Y = 8'($urandom);
      j = 1;
      @(negedge clk);
      while (!END && j < 20) begin
         BEGIN = poke && j == 4;
         @(negedge clk);
         j++;
      end
      BEGIN = 1'b0;
      chk({tag, "_lat"}, 32'(j + 1), 32'(lat));
      chk({tag, "_out"}, 32'(OUT), 32'(eo));
      chk({tag, "_ovr"}, 32'(ovr), 32'(eovr));
`ifdef ALU_DEBUG_PORTS_EN
      chk({tag, "_A"}, 32'(A), 32'(eo[15:8]));
      chk({tag, "_Q"}, 32'(Q), 32'(eo[7:0]));
      chk({tag, "_ctl"}, 32'(control), 32'h18000);
`endif
      @(negedge clk);
      chk({tag, "_endlow"}, 32'(END), 32'd0);
      chk({tag, "_hold"}, 32'(OUT), 32'(eo));
   endtask

   initial begin
      int ends;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out", 32'(OUT), 32'd0);
      chk("rst_end", 32'(END), 32'd0);
      chk("rst_ovr", 32'(ovr), 32'd0);
`ifdef ALU_DEBUG_PORTS_EN
      chk("rst_ctl", 32'(control), 32'h20000);
`endif
      resetn = 1'b1;
      run("div_nn",   3'b101, 8'hB9, 8'h85, 16'hB900, 1'b0, 11, 1'b0);
      run("mul_m3x5", 3'b100, 8'hFD, 8'h05, 16'hFFF1, 1'b0, 10, 1'b0);
      run("mul_min",  3'b100, 8'h80, 8'h80, 16'h4000, 1'b0, 10, 1'b0);
      run("mul_7xm1", 3'b100, 8'h07, 8'hFF, 16'hFFF9, 1'b0, 10, 1'b1);
      run("mul_max",  3'b100, 8'h7F, 8'h81, 16'hC0FF, 1'b0, 10, 1'b0);
      run("add_ovf",  3'b000, 8'h64, 8'h32, 16'h0096, 1'b1, 3, 1'b0);
      run("sub_ovf",  3'b001, 8'h80, 8'h01, 16'hFF7F, 1'b1, 3, 1'b0);
      run("add_neg",  3'b000, 8'hF0, 8'hF0, 16'hFFE0, 1'b0, 3, 1'b0);
      run("div_pp",   3'b101, 8'h64, 8'h07, 16'h020E, 1'b0, 11, 1'b0);
      run("div_np",   3'b101, 8'hF9, 8'h02, 16'hFFFD, 1'b0, 11, 1'b0);
      run("div_zero", 3'b101, 8'h05, 8'h00, 16'h05FF, 1'b1, 3, 1'b0);
      run("div_min",  3'b101, 8'h80, 8'hFF, 16'h0080, 1'b1, 11, 1'b0);
      run("and",      3'b010, 8'hC3, 8'h5A, 16'h0042, 1'b0, 3, 1'b0);
      run("or",       3'b011, 8'hC3, 8'h5A, 16'h00DB, 1'b0, 3, 1'b0);
      run("xor",      3'b110, 8'hC3, 8'h5A, 16'h0099, 1'b0, 3, 1'b0);
      run("rsvd",     3'b111, 8'hC3, 8'h5A, 16'h0000, 1'b0, 3, 1'b0);
      run("add_pre",  3'b000, 8'h11, 8'h22, 16'h0033, 1'b0, 3, 1'b0);
      @(negedge clk);
      op = 3'b100; X = 8'h13; Y = 8'h11; BEGIN = 1'b1;
      @(negedge clk);
      BEGIN = 1'b0;
      repeat (5) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      chk("abort_out", 32'(OUT), 32'd0);
      chk("abort_end", 32'(END), 32'd0);
      chk("abort_ovr", 32'(ovr), 32'd0);
`ifdef ALU_DEBUG_PORTS_EN
      chk("abort_ctl", 32'(control), 32'h20000);
      chk("abort_cnt", 32'(count), 32'd0);
`endif
      resetn = 1'b1;
      ends = 0;
      repeat (12) begin
         @(negedge clk);
         ends += int'(END);
      end
      chk("abort_noend", 32'(ends), 32'd0);
      chk("abort_idle_out", 32'(OUT), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
